// File: rtl/intra_pkg.sv
// Shared constants and types for the 4x4 intra mode-decision scheduler.
package intra_pkg;

    localparam int NUM_MODES   = 35;
    localparam int MODE_W      = 6;
    localparam int SAMPLE_W    = 8;
    localparam int BLK_SAMPLES = 16;
    localparam int BLK_W       = BLK_SAMPLES * SAMPLE_W;
    localparam int NB_W        = 64;

    localparam logic [MODE_W-1:0] MODE_PLANAR   = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_DC       = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_ANG_LAST = MODE_W'(34);

    // Sized forms of the mode count so counter compares stay width-exact.
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] MODE_CNT  = MODE_W'(NUM_MODES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } sched_state_t;

endpackage

// File: rtl/intra_mode_sched_if.sv
// Scheduler <-> predictor link: neighbour bus, mode issue and prediction return.
interface intra_mode_sched_if;
    import intra_pkg::*;

    logic [NB_W-1:0]     p_hor_o;
    logic [NB_W-1:0]     p_ver_o;
    logic [SAMPLE_W-1:0] p_point_o;
    logic                pred_req_o;
    logic [MODE_W-1:0]   pred_mode_o;
    logic [BLK_W-1:0]    pred_sam_i;
    logic                pred_valid_i;

    // Scheduler side
    modport master (
        output p_hor_o, p_ver_o, p_point_o, pred_req_o, pred_mode_o,
        input  pred_sam_i, pred_valid_i
    );

    // Predictor side
    modport slave (
        input  p_hor_o, p_ver_o, p_point_o, pred_req_o, pred_mode_o,
        output pred_sam_i, pred_valid_i
    );
endinterface

// File: rtl/intra_sad4x4.sv
// Combinational sum of absolute differences over one 4x4 block.
module intra_sad4x4
    import intra_pkg::*;
#(
    parameter int SAD_W = 12
) (
    input  logic [BLK_W-1:0] org,
    input  logic [BLK_W-1:0] pred,
    output logic [SAD_W-1:0] sad
);

    logic [SAMPLE_W-1:0] diff [BLK_SAMPLES];

    for (genvar gi = 0; gi < BLK_SAMPLES; gi++) begin : g_abs
        logic [SAMPLE_W-1:0] a;
        logic [SAMPLE_W-1:0] b;
        assign a        = org[gi*SAMPLE_W +: SAMPLE_W];
        assign b        = pred[gi*SAMPLE_W +: SAMPLE_W];
        assign diff[gi] = (a >= b) ? (a - b) : (b - a);
    end

    // Adder tree over the 16 per-sample differences, no saturation.
    always_comb begin
        sad = '0;
        for (int i = 0; i < BLK_SAMPLES; i++) begin
            sad = sad + SAD_W'(diff[i]);
        end
    end

endmodule

// File: rtl/intra_mode_sched.sv
// Sweeps all intra modes for one 4x4 block, scores each by SAD and reports the best.
module intra_mode_sched
    import intra_pkg::*;
#(
    parameter int SAD_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [BLK_W-1:0]     blk_org,
    input  logic [NB_W-1:0]      nb_hor,
    input  logic [NB_W-1:0]      nb_ver,
    input  logic [SAMPLE_W-1:0]  nb_point,
    intra_mode_sched_if.master   pif,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [MODE_W-1:0]    res_mode,
    output logic [SAD_W-1:0]     res_cost
);

    sched_state_t        state_reg, state_next;
    logic [BLK_W-1:0]    org_reg;
    logic [NB_W-1:0]     p_hor_reg, p_ver_reg;
    logic [SAMPLE_W-1:0] p_point_reg;
    logic [MODE_W-1:0]   iss_cnt_reg, rcv_cnt_reg, sad_mode_reg, best_mode_reg;
    logic [SAD_W-1:0]    sad_reg, best_cost_reg, sad_comb;
    logic                sad_v_reg;
    logic                accept, take_pred;

    assign accept    = blk_valid & blk_ready;
    // Predictions are only scored while a sweep is in flight and not yet complete.
    assign take_pred = pif.pred_valid_i
                     & ((state_reg == ST_ISSUE) | (state_reg == ST_DRAIN))
                     & (rcv_cnt_reg < MODE_CNT);

    intra_sad4x4 #(.SAD_W(SAD_W)) u_sad (
        .org  (org_reg),
        .pred (pif.pred_sam_i),
        .sad  (sad_comb)
    );

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_next     = state_reg;
        blk_ready      = 1'b0;
        pif.pred_req_o = 1'b0;
        res_valid      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                pif.pred_req_o = 1'b1;
                if (iss_cnt_reg == LAST_MODE) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((rcv_cnt_reg == MODE_CNT) && !sad_v_reg) state_next = ST_REPORT;
            end
            ST_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Block capture: samples and neighbours held from accept until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            org_reg     <= '0;
            p_hor_reg   <= '0;
            p_ver_reg   <= '0;
            p_point_reg <= '0;
        end else if (accept) begin
            org_reg     <= blk_org;
            p_hor_reg   <= nb_hor;
            p_ver_reg   <= nb_ver;
            p_point_reg <= nb_point;
        end
    end

    // Issue and receive counters; the issue counter parks on the last mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_cnt_reg <= '0;
            rcv_cnt_reg <= '0;
        end else if (accept) begin
            iss_cnt_reg <= '0;
            rcv_cnt_reg <= '0;
        end else begin
            if ((state_reg == ST_ISSUE) && (iss_cnt_reg != LAST_MODE))
                iss_cnt_reg <= iss_cnt_reg + 1'b1;
            if (take_pred)
                rcv_cnt_reg <= rcv_cnt_reg + 1'b1;
        end
    end

    // SAD pipeline stage; results arrive in issue order so rcv_cnt names the mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sad_v_reg    <= 1'b0;
            sad_reg      <= '0;
            sad_mode_reg <= '0;
        end else begin
            sad_v_reg <= take_pred;
            if (take_pred) begin
                sad_reg      <= sad_comb;
                sad_mode_reg <= rcv_cnt_reg;
            end
        end
    end

    // Running minimum; strict compare keeps the lower mode on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_cost_reg <= '0;
            best_mode_reg <= '0;
        end else if (accept) begin
            best_cost_reg <= '1;
            best_mode_reg <= MODE_PLANAR;
        end else if (sad_v_reg && (sad_reg < best_cost_reg)) begin
            best_cost_reg <= sad_reg;
            best_mode_reg <= sad_mode_reg;
        end
    end

    assign pif.p_hor_o     = p_hor_reg;
    assign pif.p_ver_o     = p_ver_reg;
    assign pif.p_point_o   = p_point_reg;
    assign pif.pred_mode_o = iss_cnt_reg;
    assign res_mode        = best_mode_reg;
    assign res_cost        = best_cost_reg;

endmodule

// File: tb/tb_intra_mode_sched.sv
// Self-checking bench for intra_mode_sched with a one-cycle predictor model and result scoreboard.
module tb_intra_mode_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_org;
    logic [63:0]  nb_hor, nb_ver;
    logic [7:0]   nb_point;
    logic         res_valid;
    logic         res_ready;
    logic [5:0]   res_mode;
    logic [11:0]  res_cost;

    intra_mode_sched_if pif ();

    intra_mode_sched #(.SAD_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_org   (blk_org),
        .nb_hor    (nb_hor),
        .nb_ver    (nb_ver),
        .nb_point  (nb_point),
        .pif       (pif),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_mode  (res_mode),
        .res_cost  (res_cost)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    typedef struct packed {
        logic [5:0]  m;
        logic [11:0] c;
    } exp_t;
    exp_t sb[$];

    int           cur_test = 0;
    logic [127:0] cur_org  = '0;
    logic         model_valid;
    logic [127:0] model_sam;
    logic         stray_valid = 1'b0;
    logic [127:0] stray_sam   = '0;

    assign pif.pred_valid_i = model_valid | stray_valid;
    assign pif.pred_sam_i   = stray_valid ? stray_sam : model_sam;

    // Prediction pattern each scenario's predictor returns for a given mode.
    function automatic logic [127:0] model_pred(input int tid, input int mode, input logic [127:0] org);
        logic [7:0] x;
        case (tid)
            1: return {16{8'd128}};
            2: return (mode == 26) ? org : (org ^ {16{8'h0A}});
            3: return '0;
            4: begin x = 8'((mode * 7) + 3);       return org ^ {16{x}}; end
            5: return org ^ {16{8'h0A}};
            default: begin x = 8'((mode * 13) ^ 85); return org ^ {16{x}}; end
        endcase
    endfunction

    function automatic int ref_sad(input logic [127:0] a, input logic [127:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            int x, y;
            x = int'(a[i*8 +: 8]);
            y = int'(b[i*8 +: 8]);
            s += (x > y) ? (x - y) : (y - x);
        end
        return s;
    endfunction

    // Predictor model: answers each issued mode one cycle later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_valid <= 1'b0;
            model_sam   <= '0;
        end else begin
            model_valid <= pif.pred_req_o;
            model_sam   <= model_pred(cur_test, int'(pif.pred_mode_o), cur_org);
        end
    end

    // Offers one block, tracks the sweep, optionally back-pressures, then pops the scoreboard.
    task automatic run_block(input int tid, input logic [127:0] org, input logic [63:0] hor,
                             input logic [63:0] ver, input logic [7:0] pt, input int hold,
                             output int lat, output int req_cnt, output int seq_err,
                             output int nb_err, output int stab_err, output int rdy_err,
                             output logic rdy_after, output logic [5:0] got_mode,
                             output logic [11:0] got_cost, output logic [5:0] exp_mode,
                             output logic [11:0] exp_cost);
        int   best, bm, s, c;
        exp_t e;
        lat = -1; req_cnt = 0; seq_err = 0; nb_err = 0; stab_err = 0; rdy_err = 0;
        cur_test = tid;
        cur_org  = org;
        best = 1 << 30; bm = 0;
        for (int m = 0; m < 35; m++) begin
            s = ref_sad(model_pred(tid, m, org), org);
            if (s < best) begin best = s; bm = m; end
        end
        sb.push_back({6'(bm), 12'(best)});
        @(negedge clk);
        blk_org = org; nb_hor = hor; nb_ver = ver; nb_point = pt; blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        blk_org = ~org; nb_hor = ~hor; nb_ver = ~ver; nb_point = ~pt;
        c = 0;
        while (c < 200) begin
            if (pif.pred_req_o) begin
                if (pif.pred_mode_o !== 6'(req_cnt) || c != req_cnt) seq_err++;
                req_cnt++;
            end
            if (pif.p_hor_o !== hor || pif.p_ver_o !== ver || pif.p_point_o !== pt) nb_err++;
            if (res_valid === 1'b1) begin lat = c; break; end
            @(negedge clk);
            c++;
        end
        if (lat >= 0 && hold > 0) begin
            got_mode = res_mode; got_cost = res_cost;
            blk_valid = 1'b1; stray_valid = 1'b1; stray_sam = org;
            repeat (hold) begin
                @(negedge clk);
                if (res_valid !== 1'b1 || res_mode !== got_mode || res_cost !== got_cost) stab_err++;
                if (pif.p_hor_o !== hor || pif.p_ver_o !== ver || pif.p_point_o !== pt) nb_err++;
                if (blk_ready !== 1'b0) rdy_err++;
            end
            stray_valid = 1'b0;
        end
        got_mode = res_mode; got_cost = res_cost;
        res_ready = 1'b1;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '1;
        exp_mode = e.m; exp_cost = e.c;
        @(negedge clk);
        res_ready = 1'b0; blk_valid = 1'b0;
        rdy_after = blk_ready;
        n_txn++;
        $display("txn %0d test %0d: mode=%0d cost=%0d (expect mode=%0d cost=%0d) first res_valid cycle %0d",
                 n_txn, tid, got_mode, got_cost, exp_mode, exp_cost, lat);
    endtask

    task automatic test_reset();
        n_vec++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL reset_blk_ready: got %b want 1", blk_ready); end
        n_vec++; if (pif.pred_req_o !== 1'b0) begin n_err++; $display("FAIL reset_pred_req: got %b want 0", pif.pred_req_o); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_vec++; if ({res_mode, res_cost, pif.pred_mode_o} !== 24'd0) begin n_err++; $display("FAIL reset_res_mode_cost: got %0d/%0d/%0d want 0/0/0", res_mode, res_cost, pif.pred_mode_o); end
        n_vec++; if ({pif.p_hor_o, pif.p_ver_o, pif.p_point_o} !== 136'd0) begin n_err++; $display("FAIL reset_p_out: got %h %h %h want 0", pif.p_hor_o, pif.p_ver_o, pif.p_point_o); end
    endtask

    task automatic test_flat();
        int lat, rc, se, ne, st, re; logic ra; logic [5:0] gm, em; logic [11:0] gc, ec;
        run_block(1, {16{8'd128}}, {8{8'd128}}, {8{8'd128}}, 8'd128, 0,
                  lat, rc, se, ne, st, re, ra, gm, gc, em, ec);
        n_vec++; if (lat !== 38) begin n_err++; $display("FAIL flat_latency: got %0d want 38", lat); end
        n_vec++; if (gm !== em) begin n_err++; $display("FAIL flat_mode: got %0d want %0d", gm, em); end
        n_vec++; if (gc !== ec) begin n_err++; $display("FAIL flat_cost: got %0d want %0d", gc, ec); end
    endtask

    task automatic test_best_mode26();
        int lat, rc, se, ne, st, re; logic ra; logic [5:0] gm, em; logic [11:0] gc, ec;
        logic [127:0] org;
        org = {$urandom, $urandom, $urandom, $urandom};
        run_block(2, org, 64'h0123456789abcdef, 64'hfedcba9876543210, 8'h5a, 0,
                  lat, rc, se, ne, st, re, ra, gm, gc, em, ec);
        n_vec++; if (gm !== em) begin n_err++; $display("FAIL m26_mode: got %0d want %0d", gm, em); end
        n_vec++; if (gc !== ec) begin n_err++; $display("FAIL m26_cost: got %0d want %0d", gc, ec); end
        n_vec++; if (lat !== 38) begin n_err++; $display("FAIL m26_latency: got %0d want 38", lat); end
    endtask

    task automatic test_max_cost();
        int lat, rc, se, ne, st, re; logic ra; logic [5:0] gm, em; logic [11:0] gc, ec;
        run_block(3, {16{8'hff}}, '0, '1, 8'h00, 0,
                  lat, rc, se, ne, st, re, ra, gm, gc, em, ec);
        n_vec++; if (gc !== ec) begin n_err++; $display("FAIL max_cost: got %0d want %0d", gc, ec); end
        n_vec++; if (gm !== em) begin n_err++; $display("FAIL max_mode: got %0d want %0d", gm, em); end
    endtask

    task automatic test_sequencing();
        int lat, rc, se, ne, st, re; logic ra; logic [5:0] gm, em; logic [11:0] gc, ec;
        logic [127:0] org;
        org = {$urandom, $urandom, $urandom, $urandom};
        run_block(4, org, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 0,
                  lat, rc, se, ne, st, re, ra, gm, gc, em, ec);
        n_vec++; if (rc !== 35) begin n_err++; $display("FAIL seq_req_cycles: got %0d want 35", rc); end
        n_vec++; if (se !== 0) begin n_err++; $display("FAIL seq_mode_order: got %0d bad cycles want 0", se); end
        n_vec++; if (ne !== 0) begin n_err++; $display("FAIL seq_p_stable: got %0d changed cycles want 0", ne); end
        n_vec++; if (gm !== em || gc !== ec) begin n_err++; $display("FAIL seq_result: got %0d/%0d want %0d/%0d", gm, gc, em, ec); end
    endtask

    task automatic test_back_pressure();
        int lat, rc, se, ne, st, re; logic ra; logic [5:0] gm, em; logic [11:0] gc, ec;
        logic [127:0] org;
        org = {$urandom, $urandom, $urandom, $urandom};
        run_block(5, org, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 10,
                  lat, rc, se, ne, st, re, ra, gm, gc, em, ec);
        n_vec++; if (st !== 0) begin n_err++; $display("FAIL bp_res_stable: got %0d unstable cycles want 0", st); end
        n_vec++; if (re !== 0) begin n_err++; $display("FAIL bp_blk_ready_low: got %0d high cycles want 0", re); end
        n_vec++; if (ra !== 1'b1) begin n_err++; $display("FAIL bp_blk_ready_after: got %b want 1", ra); end
        n_vec++; if (gm !== em || gc !== ec) begin n_err++; $display("FAIL bp_result: got %0d/%0d want %0d/%0d", gm, gc, em, ec); end
        n_vec++; if (ne !== 0) begin n_err++; $display("FAIL bp_p_stable: got %0d changed cycles want 0", ne); end
    endtask

    task automatic test_reset_mid();
        int lat, rc, se, ne, st, re, c; logic ra; logic [5:0] gm, em; logic [11:0] gc, ec;
        logic [127:0] org;
        org = {$urandom, $urandom, $urandom, $urandom};
        cur_test = 6; cur_org = org;
        @(negedge clk);
        blk_org = org; nb_hor = {$urandom, $urandom}; nb_ver = {$urandom, $urandom}; nb_point = 8'h33; blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        c = 0;
        while (!(pif.pred_req_o === 1'b1 && pif.pred_mode_o === 6'd17) && c < 100) begin
            @(negedge clk);
            c++;
        end
        n_vec++; if (pif.pred_mode_o !== 6'd17) begin n_err++; $display("FAIL rmid_reach_17: got %0d want 17", pif.pred_mode_o); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (blk_ready !== 1'b1 || pif.pred_req_o !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL rmid_async_ctrl: got rdy=%b req=%b rv=%b want 1 0 0", blk_ready, pif.pred_req_o, res_valid); end
        n_vec++; if ({pif.p_hor_o, pif.p_point_o, pif.pred_mode_o, res_mode, res_cost} !== 90'd0) begin n_err++; $display("FAIL rmid_async_regs: got hor=%h pt=%h mode=%0d rm=%0d rc=%0d want 0", pif.p_hor_o, pif.p_point_o, pif.pred_mode_o, res_mode, res_cost); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready_after: got %b want 1", blk_ready); end
        stray_valid = 1'b1; stray_sam = '0;
        repeat (3) @(negedge clk);
        stray_valid = 1'b0;
        n_vec++; if (res_valid !== 1'b0 || pif.pred_req_o !== 1'b0) begin n_err++; $display("FAIL rmid_stray: got rv=%b req=%b want 0 0", res_valid, pif.pred_req_o); end
        org = {$urandom, $urandom, $urandom, $urandom};
        run_block(6, org, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 0,
                  lat, rc, se, ne, st, re, ra, gm, gc, em, ec);
        n_vec++; if (gm !== em || gc !== ec) begin n_err++; $display("FAIL rmid_next_result: got %0d/%0d want %0d/%0d", gm, gc, em, ec); end
        n_vec++; if (lat !== 38 || rc !== 35) begin n_err++; $display("FAIL rmid_next_timing: got lat %0d reqs %0d want 38 35", lat, rc); end
    endtask

    initial begin
        rst = 1'b0; blk_valid = 1'b0; res_ready = 1'b0;
        blk_org = '0; nb_hor = '0; nb_ver = '0; nb_point = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_flat();
        test_best_mode26();
        test_max_cost();
        test_sequencing();
        test_back_pressure();
        test_reset_mid();
        n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
